// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//   Multi-cycle unsigned restoring divider. It produces one quotient bit per
//   clock and uses a start/busy/done handshake. It reads the divisor register
//   on the divide path and feeds the ALU result mux.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; has priority over start
//   start        request a division; sampled only while idle
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high whenever the FSM is not idle
//   done         one-cycle pulse; results are valid from this cycle on
//   quotient     quotient, held until replaced by the next result
//   remainder    remainder, held until replaced by the next result
//   div_by_zero  set with done when the divisor was zero; held with results
//
// Timing (WIDTH=32)
//   Normal division: done is high 32 edges after the accepting edge.
//   busy is high for 33 cycles.
//   Divide by zero: done is high in the cycle after the accepting edge.
//   busy is high for 1 cycle.
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] d_q, d_d;          // captured divisor
    logic [WIDTH:0]   r_q, r_d;          // partial remainder, one guard bit
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    // One restoring step. R < D holds on entry, so the shifted value is below
    // 2*D. The WIDTH+1-bit subtraction therefore cannot wrap, and its MSB is
    // the borrow.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = r_shift - {1'b0, d_q};
        if (!trial[WIDTH]) begin
            r_step = trial;
            q_step = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            r_step = r_shift;
            q_step = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        // Skip iteration entirely: quotient saturates and the
                        // dividend passes through as the remainder.
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quot_d  = q_step;
                    rem_d   = r_step[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Scoreboard bench for seq_restoring_divider (WIDTH=32). The bench pushes
//   an expected result whenever it drives a start that the divider must
//   accept. A monitor pops and compares an entry on every done pulse. The
//   stimulus tasks also check latency and busy length.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        sb.push_back(e);
        n_push++;
    endfunction

    // Result monitor: every done pulse must match the oldest outstanding entry.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("extra_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("quot", 64'(quotient), 64'(mon_e.q));
                check("rem",  64'(remainder), 64'(mon_e.r));
                check("dbz",  64'(div_by_zero), 64'(mon_e.z));
                if (mon_e.b != '0) begin
                    check("ident", 64'(quotient) * 64'(mon_e.b) + 64'(remainder), 64'(mon_e.a));
                    check("rem_lt_div", 64'(remainder < mon_e.b), 64'd1);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
    endtask

    // Drive start for exactly one edge (E0). Return at the negedge after E0
    // with start low and the operands scrambled.
    task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Full division with latency and busy-length checks.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        int lat = -1;
        int bcnt = 0;
        push(a, b);
        kick(a, b);
        while (busy && n < 100) begin
            if (done) lat = n;
            bcnt++;
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("run_timeout", 64'd1, 64'd0);
        check("latency",  64'(lat),  (b == '0) ? 64'd0 : 64'(W));
        check("busy_len", 64'(bcnt), (b == '0) ? 64'd1 : 64'(W + 1));
    endtask

    initial begin
        int d0;
        int t1;
        int t2;
        int t3;
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quot", 64'(quotient), 64'd0);
        check("rst_rem",  64'(remainder), 64'd0);
        check("rst_dbz",  64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic and edge-value operands
        run(32'd100, 32'd7);
        run(32'hFFFF_FFFF, 32'd1);
        run(32'd5, 32'd10);
        run(32'h8000_0000, 32'h8000_0000);

        // Divide by zero, then a normal divide clears the flag
        run(32'd1234, 32'd0);
        check("dbz_hold", 64'(div_by_zero), 64'd1);
        run(32'd9, 32'd3);

        // Start while busy is ignored
        d0 = done_cnt;
        push(32'd50, 32'd5);
        kick(32'd50, 32'd5);
        repeat (10) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("busy_start_dones", 64'(done_cnt - d0), 64'd1);

        // Reset mid-operation (no result expected from the aborted divide)
        kick(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_quot", 64'(quotient), 64'd0);
        check("mid_rst_rem",  64'(remainder), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run(32'd1000, 32'd3);

        // Back-to-back with start held: three accepts, 34 edges apart
        wait_idle();
        push(32'd20, 32'd6);
        push(32'd20, 32'd6);
        push(32'd20, 32'd6);
        d0 = done_cnt;
        t1 = -1;
        t2 = -1;
        t3 = -1;
        n  = 0;
        start    = 1'b1;
        dividend = 32'd20;
        divisor  = 32'd6;
        while (done_cnt - d0 < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
                else t3 = n;
            end
        end
        start = 1'b0;
        if (n >= 300) check("b2b_timeout", 64'd1, 64'd0);
        check("b2b_gap1", 64'(t2 - t1), 64'd34);
        check("b2b_gap2", 64'(t3 - t2), 64'd34);
        wait_idle();
        repeat (3) @(negedge clk);

        // Random operand pairs
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1, 2, 3: rb = $urandom_range(1, 255);
                4:       rb = ra;
                default: rb = $urandom;
            endcase
            run(ra, rb);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("done_total", 64'(done_cnt), 64'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
